arty_boot_sequencer: RTL
========================

// Module: arty_boot_sequencer
// PURPOSE
//  Sequences PULPino SoC bring-up on the Arty board: waits for a stable MMCM lock,
//  holds the SoC in reset for a fixed time, releases reset, then gates the board
//  fetch-enable switch through to the core. Sits between arty_mmcm and pulpino in arty_top.
//  Drives the SoC rst_n and fetch_enable_i; re-runs the sequence on lock loss.
// PARAMETERS
//  LOCK_FILTER  8           cycles pll_locked must stay high before leaving WAIT_LOCK
//  HOLD_CYCLES  1024        cycles SoC reset is held low after lock qualifies
//  FETCH_DELAY  16          cycles between reset release and fetch_enable_o allowed high
//  WDT_CYCLES   50000000    watchdog timeout in cycles (only with BOOT_WATCHDOG_EN)
// PORTS
//  clk             in   1  CPU clock (clk_cpu from arty_mmcm)
//  rst             in   1  async active-high reset
//  pll_locked_i    in   1  MMCM lock, asynchronous to clk
//  fetch_en_req_i  in   1  board fetch-enable switch, asynchronous
//  heartbeat_i     in   1  SoC heartbeat (e.g. gpio_out[8]), used by watchdog only
//  soc_rst_n_o     out  1  active-low reset to pulpino
//  fetch_enable_o  out  1  fetch enable to pulpino
//  state_o         out  3  current FSM state encoding
//  wdt_fired_o     out  1  sticky: watchdog has forced a reset since rst
// BEHAVIOUR
//  - pll_locked_i, fetch_en_req_i, heartbeat_i each pass a 2-flop synchronizer (2-cycle latency);
//    all logic below sees synchronized versions (lk, fe, hb).
//  - Reset (rst=1, async): state=WAIT_LOCK (3'd0), counter=0, soc_rst_n_o=0,
//    fetch_enable_o=0, wdt_fired_o=0, sync flops=0. All outputs registered.
//  - States: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3.
//  - WAIT_LOCK: counter increments while lk=1, clears to 0 when lk=0; at counter==LOCK_FILTER-1
//    with lk=1 -> HOLD, counter=0. soc_rst_n_o=0.
//  - HOLD: soc_rst_n_o=0; counter counts to HOLD_CYCLES-1 -> RELEASE, counter=0.
//  - RELEASE: soc_rst_n_o=1 (rises the cycle after entering RELEASE); counter counts to
//    FETCH_DELAY-1 -> RUN. fetch_enable_o=0.
//  - RUN: soc_rst_n_o=1; fetch_enable_o = fe registered (1 cycle after fe), tracks switch both ways.
//  - Lock loss: lk=0 in HOLD/RELEASE/RUN -> WAIT_LOCK next cycle; soc_rst_n_o and
//    fetch_enable_o go 0 on that same edge; counter=0. Lock loss takes priority over all.
//  - fetch_enable_o is never 1 while soc_rst_n_o=0.
//  - Counter width $clog2(max(LOCK_FILTER,HOLD_CYCLES,FETCH_DELAY,WDT_CYCLES))+1; no wrap;
//    parameters of 1 give a single-cycle dwell in that state.
//  - rst asserted mid-sequence: immediate return to reset values, sequence restarts.
// CONFIGURATION
//  BOOT_WATCHDOG_EN defined: in RUN, a separate watchdog counter clears on any hb edge
//    (hb != hb delayed) and increments otherwise; at WDT_CYCLES-1 -> HOLD (counter=0),
//    wdt_fired_o set to 1 (cleared only by rst). Watchdog counter held 0 outside RUN.
//    Lock loss beats watchdog expiry in the same cycle.
//  BOOT_WATCHDOG_EN undefined: no watchdog logic; heartbeat_i unused; wdt_fired_o tied 0.
// TESTING (bench parameters LOCK_FILTER=4, HOLD_CYCLES=8, FETCH_DELAY=3, WDT_CYCLES=20)
//  1. rst 1->0, pll_locked_i=1, fetch_en_req_i=1 -> soc_rst_n_o rises exactly 2+4+8 cycles after
//     synchronized lock (state 0->1->2), fetch_enable_o rises 3+1 cycles later (state 3).
//  2. pll_locked_i glitches high 3 cycles then low -> stays WAIT_LOCK, soc_rst_n_o=0 throughout.
//  3. In RUN, drop pll_locked_i -> 2 cycles after sync, state=0, soc_rst_n_o=0, fetch_enable_o=0
//     same edge; restore lock -> full sequence repeats with identical timing.
//  4. In RUN, toggle fetch_en_req_i 1->0->1 -> fetch_enable_o follows with 3-cycle latency;
//     fetch_en_req_i=1 during HOLD/RELEASE -> fetch_enable_o stays 0.
//  5. BOOT_WATCHDOG_EN: in RUN toggle heartbeat_i every 10 cycles -> no reset; stop toggling ->
//     after 20 cycles state=1, soc_rst_n_o=0, wdt_fired_o=1 and stays 1 after returning to RUN.
//  6. Assert rst during RELEASE -> all outputs at reset values asynchronously, before next clk edge.

Source files
------------

// File: rtl/arty_boot_sequencer_if.sv
// Bring-up signals between the Arty clocking/board I/O and the PULPino boot sequencer.
// The sequencer uses the slave modport; whatever drives the board-side inputs uses master.
`timescale 1ns/1ps
interface arty_boot_sequencer_if;
   logic       pll_locked_i;
   logic       fetch_en_req_i;
   logic       heartbeat_i;
   logic       soc_rst_n_o;
   logic       fetch_enable_o;
   logic [2:0] state_o;
   logic       wdt_fired_o;

   modport master (
      output pll_locked_i,
      output fetch_en_req_i,
      output heartbeat_i,
      input  soc_rst_n_o,
      input  fetch_enable_o,
      input  state_o,
      input  wdt_fired_o
   );

   modport slave (
      input  pll_locked_i,
      input  fetch_en_req_i,
      input  heartbeat_i,
      output soc_rst_n_o,
      output fetch_enable_o,
      output state_o,
      output wdt_fired_o
   );
endinterface

// File: rtl/arty_boot_sequencer.sv
// PULPino bring-up sequencer: qualify MMCM lock, hold SoC reset, release it, then gate fetch enable.
// Define BOOT_WATCHDOG_EN to add a heartbeat watchdog that re-enters HOLD when the SoC stalls in RUN.
`timescale 1ns/1ps
module arty_boot_sequencer #(
   parameter int LOCK_FILTER = 8,
   parameter int HOLD_CYCLES = 1024,
   parameter int FETCH_DELAY = 16,
   parameter int WDT_CYCLES  = 50000000
) (
   input  logic                  clk,
   input  logic                  rst,
   arty_boot_sequencer_if.slave  bus
);

   localparam int MAX_LH  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
   localparam int MAX_LHF = (MAX_LH > FETCH_DELAY) ? MAX_LH : FETCH_DELAY;
   localparam int MAX_ALL = (MAX_LHF > WDT_CYCLES) ? MAX_LHF : WDT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL) + 1;

   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic             r_socRstN;
   logic             w_socRstNNext;
   logic             r_fetchEn;
   logic             w_fetchEnNext;
   logic             r_lkMeta;
   logic             r_lk;
   logic             r_feMeta;
   logic             r_fe;

`ifdef BOOT_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

   logic             r_hbMeta;
   logic             r_hb;
   logic             r_hbDly;
   logic [CNT_W-1:0] r_wdtCnt;
   logic [CNT_W-1:0] w_wdtCntNext;
   logic             r_wdtFired;
   logic             w_wdtFiredNext;
`endif

   // Lock and the fetch switch come from other clock domains; two flops each before use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lkMeta <= 1'b0;
         r_lk     <= 1'b0;
         r_feMeta <= 1'b0;
         r_fe     <= 1'b0;
      end else begin
         r_lkMeta <= bus.pll_locked_i;
         r_lk     <= r_lkMeta;
         r_feMeta <= bus.fetch_en_req_i;
         r_fe     <= r_feMeta;
      end
   end

`ifdef BOOT_WATCHDOG_EN
   // Heartbeat synchronizer plus one extra delay stage for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hbMeta   <= 1'b0;
         r_hb       <= 1'b0;
         r_hbDly    <= 1'b0;
         r_wdtCnt   <= '0;
         r_wdtFired <= 1'b0;
      end else begin
         r_hbMeta   <= bus.heartbeat_i;
         r_hb       <= r_hbMeta;
         r_hbDly    <= r_hb;
         r_wdtCnt   <= w_wdtCntNext;
         r_wdtFired <= w_wdtFiredNext;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= WAIT_LOCK;
         r_cnt     <= '0;
         r_socRstN <= 1'b0;
         r_fetchEn <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_socRstN <= w_socRstNNext;
         r_fetchEn <= w_fetchEnNext;
      end
   end

   // Lock loss is checked first in every post-lock state so it always wins.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
`ifdef BOOT_WATCHDOG_EN
      w_wdtCntNext   = '0;
      w_wdtFiredNext = r_wdtFired;
`endif
      case (r_state)
         WAIT_LOCK: begin
            if (!r_lk) begin
               w_cntNext = '0;
            end else if (r_cnt == LOCK_LAST) begin
               w_stateNext = HOLD;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         HOLD: begin
            if (!r_lk) begin
               w_stateNext = WAIT_LOCK;
               w_cntNext   = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_stateNext = RELEASE;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         RELEASE: begin
            if (!r_lk) begin
               w_stateNext = WAIT_LOCK;
               w_cntNext   = '0;
            end else if (r_cnt == FETCH_LAST) begin
               w_stateNext = RUN;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         RUN: begin
            w_cntNext = '0;
            if (!r_lk) begin
               w_stateNext = WAIT_LOCK;
            end
`ifdef BOOT_WATCHDOG_EN
            else if (r_wdtCnt == WDT_LAST) begin
               w_stateNext    = HOLD;
               w_wdtFiredNext = 1'b1;
            end else if (r_hb != r_hbDly) begin
               w_wdtCntNext = '0;
            end else begin
               w_wdtCntNext = r_wdtCnt + 1'b1;
            end
`endif
         end
         default: begin
            w_stateNext = WAIT_LOCK;
            w_cntNext   = '0;
         end
      endcase

      // Both outputs drop on the same edge that leaves RELEASE/RUN, so fetch never outlives reset.
      w_socRstNNext = ((r_state == RELEASE) || (r_state == RUN)) &&
                      ((w_stateNext == RELEASE) || (w_stateNext == RUN));
      w_fetchEnNext = (r_state == RUN) && (w_stateNext == RUN) && r_fe;
   end

   assign bus.soc_rst_n_o    = r_socRstN;
   assign bus.fetch_enable_o = r_fetchEn;
   assign bus.state_o        = r_state;
`ifdef BOOT_WATCHDOG_EN
   assign bus.wdt_fired_o    = r_wdtFired;
`else
   assign bus.wdt_fired_o    = 1'b0;
`endif

endmodule
